// File: rtl/imem_prog_pkg.sv
// Shared types and sizing helpers for the programmable instruction memory.
package imem_prog_pkg;

  typedef enum logic [1:0] {
    StClear = 2'd0,
    StLoad  = 2'd1,
    StRun   = 2'd2
  } state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NopWord = 32'h0000_0013;

  function automatic int unsigned calc_bpw(input int unsigned data_width);
    return data_width / 8;
  endfunction

  function automatic int unsigned calc_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// Assembles loader bytes MSB-first into instruction words; a short final word
// is emitted with its missing low bytes left at zero.
module imem_byte_packer
  import imem_prog_pkg::*;
#(
  parameter int unsigned DATA_BUS_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      accept,
  input  logic [7:0]                in_data,
  input  logic                      in_last,
  output logic                      word_valid,
  output logic [DATA_BUS_WIDTH-1:0] word
);

  localparam int unsigned Bpw  = calc_bpw(DATA_BUS_WIDTH);
  localparam int unsigned CntW = $clog2(Bpw) + 1;

  logic [DATA_BUS_WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]           byte_cnt_q, byte_cnt_d;

  // Current byte lands in its slot so a completing word is visible this cycle.
  always_comb begin
    word = shift_q;
    for (int i = 0; i < int'(Bpw); i++) begin
      if (byte_cnt_q == CntW'(i)) begin
        word[DATA_BUS_WIDTH-1-8*i -: 8] = in_data;
      end
    end
  end

  assign word_valid = accept && (in_last || (byte_cnt_q == CntW'(Bpw - 1)));

  always_comb begin
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    if (flush) begin
      shift_d    = '0;
      byte_cnt_d = '0;
    end else if (accept) begin
      if (word_valid) begin
        shift_d    = '0;
        byte_cnt_d = '0;
      end else begin
        shift_d    = word;
        byte_cnt_d = byte_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      byte_cnt_q <= '0;
    end else begin
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

endmodule

// File: rtl/imem_prog.sv
// Instruction memory with combinational fetch and a byte-stream program loader
// that NOP-fills the array after reset and before every load.
module imem_prog
  import imem_prog_pkg::*;
#(
  parameter int unsigned                ADDR_BUS_WIDTH = 16,
  parameter int unsigned                DATA_BUS_WIDTH = 32,
  parameter int unsigned                MEM_WORDS      = 64,
  parameter logic [DATA_BUS_WIDTH-1:0]  NOP_WORD       = DATA_BUS_WIDTH'(NopWord)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ADDR_BUS_WIDTH-1:0]     a,
  output logic [DATA_BUS_WIDTH-1:0]     rd,
  output logic                          misaligned,
  output logic                          oob,
  input  logic                          load_start,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  input  logic                          in_last,
  output logic                          in_ready,
  output logic                          busy,
  output logic                          load_done,
  output logic                          overflow,
  output logic [$clog2(MEM_WORDS):0]    words_loaded
);

  localparam int unsigned Bpw  = calc_bpw(DATA_BUS_WIDTH);
  localparam int unsigned OffW = $clog2(Bpw);
  localparam int unsigned IdxW = calc_idx_w(MEM_WORDS);
  localparam int unsigned PtrW = $clog2(MEM_WORDS) + 1;

  state_e                    state_q, state_d;
  logic [PtrW-1:0]           ptr_q, ptr_d;
  logic [PtrW-1:0]           words_loaded_q, words_loaded_d;
  logic                      reload_q, reload_d;
  logic                      overflow_q, overflow_d;
  logic                      load_done_q, load_done_d;

  logic [DATA_BUS_WIDTH-1:0] mem_q [MEM_WORDS];
  logic                      mem_we;
  logic [DATA_BUS_WIDTH-1:0] mem_wdata;

  logic                      accept, full, word_valid;
  logic [DATA_BUS_WIDTH-1:0] packed_word;
  logic [ADDR_BUS_WIDTH-1:0] widx;

  assign busy         = (state_q != StRun);
  assign in_ready     = (state_q == StLoad) && !load_start;
  assign accept       = in_valid && in_ready;
  assign full         = (ptr_q == PtrW'(MEM_WORDS));
  assign load_done    = load_done_q;
  assign overflow     = overflow_q;
  assign words_loaded = words_loaded_q;

  // Fetch port: low address bits are ignored for the word lookup.
  assign widx       = a >> OffW;
  assign misaligned = (a & ADDR_BUS_WIDTH'(Bpw - 1)) != '0;
  assign oob        = 32'(widx) >= MEM_WORDS;
  assign rd         = (busy || oob) ? NOP_WORD : mem_q[widx[IdxW-1:0]];

  imem_byte_packer #(
    .DATA_BUS_WIDTH (DATA_BUS_WIDTH)
  ) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (load_start),
    .accept     (accept),
    .in_data    (in_data),
    .in_last    (in_last),
    .word_valid (word_valid),
    .word       (packed_word)
  );

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    reload_d       = reload_q;
    overflow_d     = overflow_q;
    words_loaded_d = words_loaded_q;
    load_done_d    = 1'b0;
    mem_we         = 1'b0;
    mem_wdata      = NOP_WORD;
    if (load_start) begin
      state_d        = StClear;
      ptr_d          = '0;
      reload_d       = 1'b1;
      overflow_d     = 1'b0;
      words_loaded_d = '0;
    end else begin
      case (state_q)
        StClear: begin
          mem_we = 1'b1;
          if (ptr_q == PtrW'(MEM_WORDS - 1)) begin
            ptr_d    = '0;
            state_d  = reload_q ? StLoad : StRun;
            reload_d = 1'b0;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
        StLoad: begin
          if (word_valid && !full) begin
            mem_we         = 1'b1;
            mem_wdata      = packed_word;
            ptr_d          = ptr_q + 1'b1;
            words_loaded_d = words_loaded_q + 1'b1;
          end
          // Past the end of the array bytes are consumed but dropped.
          if (accept && full) overflow_d = 1'b1;
          if (accept && in_last) begin
            state_d     = StRun;
            load_done_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StClear;
      ptr_q          <= '0;
      reload_q       <= 1'b0;
      overflow_q     <= 1'b0;
      words_loaded_q <= '0;
      load_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      reload_q       <= reload_d;
      overflow_q     <= overflow_d;
      words_loaded_q <= words_loaded_d;
      load_done_q    <= load_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[ptr_q[IdxW-1:0]] <= mem_wdata;
  end

endmodule
